rms_peak_meter: RTL and testbench
=================================

// Module: rms_peak_meter
// PURPOSE
//   Parametrised windowed RMS and peak-magnitude meter for the DAC sample stream.
//   Generalises the fixed 12-bit meter: width, window length and input coding are
//   selectable. Sits beside the SPI DAC driver and takes the same sample and ce1us strobe.
//   Feeds a mux and then BIN12_to_DEC4; its ok pulse is the converter's start.
// PARAMETERS
//   W          12   sample width; rms/pk outputs are also W bits
//   LOG_N      10   window = N = 2^LOG_N accepted samples; constraint N >= W+2
//   OFFSET_BIN 1    1: x is offset-binary, d = x - 2^(W-1); 0: x is two's complement, d = x
// PORTS
//   clk    in   1            system clock, all logic on rising edge
//   rst_n  in   1            synchronous reset, active low
//   ce     in   1            sample strobe; x is accepted only when ce=1
//   x      in   W            input sample
//   clr    in   1            abort: restart the current window and cancel any sqrt in flight
//   rms    out  W            floor(sqrt(floor(sum(d^2)/N))) of the last completed window
//   pk     out  W            max |d| of the last completed window
//   ok     out  1            1-cycle pulse; rms/pk updated in that same cycle
//   busy   out  1            1 while the sqrt engine is running
//   tmes   out  1            toggles at every window close (scope marker)
// BEHAVIOUR
//   Reset (rst_n=0 at an edge): rms=0, pk=0, ok=0, busy=0, tmes=0.
//     Also clears the accumulator, window count, window peak and sqrt state.
//   Arithmetic, per accepted sample:
//     d is signed W bits; |d| is W bits, max 2^(W-1).
//     acc (2W-1+LOG_N bits) += d*d, computed and added in the same edge.
//     wpk = max(wpk, |d|). No overflow is possible at these widths.
//   Window: cnt (LOG_N bits) increments on each ce and wraps N-1 -> 0.
//     The edge that accepts the sample with cnt=N-1 is the close edge (C).
//   At edge C:
//     - mean = (acc + d*d) >> LOG_N is loaded into the sqrt radicand.
//     - wpk including this sample goes to the pk shadow.
//     - acc, wpk and cnt are cleared, so the next window starts at the next ce.
//     - tmes toggles and busy goes to 1.
//   Accumulation never pauses: the next window accumulates while the sqrt runs.
//   Sqrt engine: restoring, one result bit per clock, MSB first, W iterations.
//     States: IDLE -> (edge C) SQRT[W-1..0] -> DONE -> IDLE.
//   DONE edge (edge C+W+1): rms <= root, pk <= pk shadow, busy <= 0, ok=1 for one cycle.
//     So ok is high in the cycle after edge C+W+1.
//     Result is floor; an exact square gives the exact root.
//   N >= W+2 guarantees a window cannot close while the sqrt is still running.
//   clr=1 at an edge:
//     - acc, wpk and cnt are cleared; a ce in the same cycle is discarded (clr wins).
//     - A sqrt in flight is abandoned: busy <= 0, no ok, rms/pk keep their old values.
//     - tmes is unchanged.
//   ce=0: no state change except sqrt progress. The sqrt advances every clk, not on ce.
//   Between ok pulses rms/pk hold steady, so downstream may sample them at any time.
// TESTING (W=12, OFFSET_BIN=1, LOG_N=4 unless noted, ce every cycle)
//   1. Reset, then 16 samples of x=2048 -> ok once, rms=0, pk=0, tmes=1.
//   2. 16 samples of x=2148 -> rms=100, pk=100.
//      Check ok asserts exactly W+1=13 clocks after the edge accepting sample 16.
//   3. Alternating x=3048/1048 for 32 samples -> two ok pulses, each with rms=1000, pk=1000.
//      tmes toggles twice.
//   4. Extremes: 16 samples of x=0 -> rms=2048, pk=2048.
//      Repeat with OFFSET_BIN=0 and x=12'h800 -> same result.
//   5. Abort: 8 samples of x=2148, clr=1 together with a ce, then 16 samples of x=2058
//      -> rms=10, pk=10. Also pulse clr while busy=1 -> no ok, outputs unchanged.
//   6. ce every 5th clock, window of 16 samples of x=2048+d: 8 with d=+3, 8 with d=-4
//      -> mean=12, rms=3, pk=4. Then rst_n=0 while busy -> all outputs 0, no ok.

Source files
------------

// File: rtl/rms_peak_meter.sv
// Windowed RMS and peak-magnitude meter: accumulates d^2 and max |d| over 2^LOG_N
// accepted samples, then runs a bit-serial restoring square root on the window mean.
//
// state  | meaning
// S_IDLE | no root in progress; outputs hold the last completed window
// S_SQRT | one root bit per clock, MSB first, it_cnt counts down to 0
// S_DONE | root complete; publish rms/pk and pulse ok
module rms_peak_meter #(
    parameter int W          = 12,
    parameter int LOG_N      = 10,
    parameter int OFFSET_BIN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic [W-1:0] x,
    input  logic         clr,
    output logic [W-1:0] rms,
    output logic [W-1:0] pk,
    output logic         ok,
    output logic         busy,
    output logic         tmes
);

    localparam int MW = 2*W - 1;
    localparam int AW = MW + LOG_N;
    localparam int IW = (W > 2) ? $clog2(W) : 1;
    localparam logic [W-1:0]     MSB_MASK = {1'b1, {(W-1){1'b0}}};
    localparam logic [LOG_N-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_SQRT, S_DONE} state_t;

    state_t              state;
    logic [AW-1:0]       acc;
    logic [W-1:0]        wpk;
    logic [LOG_N-1:0]    cnt;
    logic [W-1:0]        pk_shadow;
    logic [2*W-1:0]      rad;
    logic [W-1:0]        rem;
    logic [W-1:0]        root;
    logic [IW-1:0]       it_cnt;

    logic [W-1:0]        d_u;
    logic signed [W-1:0] d;
    logic signed [MW-1:0] sq;
    logic [W-1:0]        mag;
    logic [W-1:0]        wpk_next;
    logic [AW-1:0]       acc_next;
    logic                close;
    logic [W+1:0]        rem_sh;
    logic [W+1:0]        trial;
    logic [W-1:0]        diff;
    logic                take;

    // Offset-binary to two's complement is just an MSB flip.
    assign d_u      = (OFFSET_BIN != 0) ? (x ^ MSB_MASK) : x;
    assign d        = signed'(d_u);
    assign sq       = d * d;
    assign mag      = d_u[W-1] ? (~d_u + 1'b1) : d_u;
    assign wpk_next = (mag > wpk) ? mag : wpk;
    assign acc_next = acc + AW'(unsigned'(sq));
    assign close    = ce && (cnt == CNT_MAX);

    // Remainder stays below 2^W, so the low W bits of the difference are exact when taken.
    assign rem_sh = {rem, rad[2*W-1:2*W-2]};
    assign trial  = {root, 2'b01};
    assign take   = (rem_sh >= trial);
    assign diff   = rem_sh[W-1:0] - trial[W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            acc       <= '0;
            wpk       <= '0;
            cnt       <= '0;
            pk_shadow <= '0;
            rad       <= '0;
            rem       <= '0;
            root      <= '0;
            it_cnt    <= '0;
            rms       <= '0;
            pk        <= '0;
            ok        <= 1'b0;
            busy      <= 1'b0;
            tmes      <= 1'b0;
        end else begin
            ok <= 1'b0;
            if (clr) begin
                acc   <= '0;
                wpk   <= '0;
                cnt   <= '0;
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                if (close) begin
                    acc       <= '0;
                    wpk       <= '0;
                    cnt       <= '0;
                    rad       <= {1'b0, acc_next[AW-1:LOG_N]};
                    rem       <= '0;
                    root      <= '0;
                    it_cnt    <= IW'(W-1);
                    pk_shadow <= wpk_next;
                    tmes      <= ~tmes;
                    busy      <= 1'b1;
                    state     <= S_SQRT;
                end else begin
                    if (ce) begin
                        acc <= acc_next;
                        wpk <= wpk_next;
                        cnt <= cnt + 1'b1;
                    end
                    case (state)
                        S_SQRT: begin
                            rad    <= rad << 2;
                            rem    <= take ? diff : rem_sh[W-1:0];
                            root   <= {root[W-2:0], take};
                            it_cnt <= it_cnt - 1'b1;
                            if (it_cnt == '0)
                                state <= S_DONE;
                        end
                        S_DONE: begin
                            rms   <= root;
                            pk    <= pk_shadow;
                            busy  <= 1'b0;
                            ok    <= 1'b1;
                            state <= S_IDLE;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_rms_peak_meter.sv
// Bench for rms_peak_meter (W=12, LOG_N=4): a sample-queue model with integer sqrt
// predicts each window's rms/pk and the edge at which ok must appear.
module tb_rms_peak_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b0;
    logic        clr = 1'b0;
    logic [11:0] x = '0;
    logic [11:0] x2 = '0;
    logic [11:0] rms, pk, rms2, pk2;
    logic        ok, busy, tmes, ok2, busy2, tmes2;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    int close_edge = 0;
    bit pending = 0;
    logic m_tmes = 1'b0;
    int m_last_rms = 0;
    int m_last_pk = 0;
    int win_q[$];
    int exp_rms_q[$], exp_pk_q[$], exp_edge_q[$];
    int act_rms_q[$], act_pk_q[$], act_edge_q[$];

    always #5 clk = ~clk;

    rms_peak_meter #(.W(12), .LOG_N(4), .OFFSET_BIN(1)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .x(x), .clr(clr),
        .rms(rms), .pk(pk), .ok(ok), .busy(busy), .tmes(tmes)
    );

    rms_peak_meter #(.W(12), .LOG_N(4), .OFFSET_BIN(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .x(x2), .clr(clr),
        .rms(rms2), .pk(pk2), .ok(ok2), .busy(busy2), .tmes(tmes2)
    );

    function automatic int isqrt(input longint m);
        int r = 0;
        while (longint'(r + 1) * longint'(r + 1) <= m) r++;
        return r;
    endfunction

    task automatic drop_pending();
        if (pending) begin
            void'(exp_rms_q.pop_back());
            void'(exp_pk_q.pop_back());
            void'(exp_edge_q.pop_back());
            pending = 0;
        end
    endtask

    // Applies one clock of stimulus, advances the model over that edge, then samples ok.
    task automatic step(input logic c, input logic [11:0] xv, input logic cl);
        longint s;
        int p;
        ce = c; clr = cl; x = xv; x2 = xv ^ 12'h800;
        @(posedge clk);
        edge_n++;
        if (!rst_n) begin
            win_q.delete();
            drop_pending();
            m_tmes = 1'b0;
        end else if (cl) begin
            win_q.delete();
            drop_pending();
        end else begin
            if (pending && edge_n == close_edge + 13) pending = 0;
            if (c) begin
                win_q.push_back(int'(xv) - 2048);
                if (win_q.size() == 16) begin
                    s = 0; p = 0;
                    foreach (win_q[i]) begin
                        s += longint'(win_q[i]) * longint'(win_q[i]);
                        if ((win_q[i] < 0 ? -win_q[i] : win_q[i]) > p)
                            p = (win_q[i] < 0) ? -win_q[i] : win_q[i];
                    end
                    m_last_rms = isqrt(s / 16);
                    m_last_pk  = p;
                    exp_rms_q.push_back(m_last_rms);
                    exp_pk_q.push_back(m_last_pk);
                    exp_edge_q.push_back(edge_n + 13);
                    close_edge = edge_n;
                    pending = 1;
                    m_tmes = ~m_tmes;
                    win_q.delete();
                end
            end
        end
        #1;
        if (ok === 1'b1) begin
            act_rms_q.push_back(int'(rms));
            act_pk_q.push_back(int'(pk));
            act_edge_q.push_back(edge_n);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 12'd0, 1'b0);
    endtask

    task automatic clear_q();
        exp_rms_q.delete(); exp_pk_q.delete(); exp_edge_q.delete();
        act_rms_q.delete(); act_pk_q.delete(); act_edge_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 12'($urandom), 1'b0);
        checks++;
        if ({rms, pk, ok, busy, tmes} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rms=%0d pk=%0d ok=%b busy=%b tmes=%b want all 0", rms, pk, ok, busy, tmes);
        end
        checks++;
        if ({rms2, pk2, ok2, busy2, tmes2} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs_tc: got rms=%0d pk=%0d ok=%b busy=%b tmes=%b want all 0", rms2, pk2, ok2, busy2, tmes2);
        end
        rst_n = 1'b1;
        clear_q();
    endtask

    task automatic test_zero();
        clear_q();
        for (int i = 0; i < 16; i++) step(1'b1, 12'd2048, 1'b0);
        idle(16);
        checks++;
        if (act_rms_q.size() != 1) begin
            errors++; $display("FAIL zero_ok_count: got %0d want 1", act_rms_q.size());
        end
        checks++;
        if (rms !== 12'd0 || pk !== 12'd0) begin
            errors++; $display("FAIL zero_values: got rms=%0d pk=%0d want 0 0", rms, pk);
        end
        checks++;
        if (tmes !== 1'b1 || tmes !== m_tmes) begin
            errors++; $display("FAIL zero_tmes: got %b want 1", tmes);
        end
    endtask

    task automatic test_latency();
        int c;
        clear_q();
        for (int i = 0; i < 16; i++) step(1'b1, 12'd2148, 1'b0);
        c = edge_n;
        idle(16);
        checks++;
        if (act_edge_q.size() != 1 || act_edge_q[0] - c != 13) begin
            errors++;
            $display("FAIL latency: got %0d ok pulses, first %0d edges after close, want 1 at 13",
                     act_edge_q.size(), (act_edge_q.size() > 0) ? act_edge_q[0] - c : -1);
        end
        checks++;
        if (rms !== 12'd100 || pk !== 12'd100) begin
            errors++; $display("FAIL latency_values: got rms=%0d pk=%0d want 100 100", rms, pk);
        end
        checks++;
        if (rms2 !== 12'd100 || pk2 !== 12'd100) begin
            errors++; $display("FAIL latency_values_tc: got rms=%0d pk=%0d want 100 100", rms2, pk2);
        end
    endtask

    task automatic test_alternating();
        logic t0;
        clear_q();
        t0 = tmes;
        for (int i = 0; i < 32; i++) step(1'b1, (i % 2 == 0) ? 12'd3048 : 12'd1048, 1'b0);
        idle(16);
        checks++;
        if (act_rms_q.size() != 2) begin
            errors++; $display("FAIL alt_ok_count: got %0d want 2", act_rms_q.size());
        end
        for (int i = 0; i < act_rms_q.size(); i++) begin
            checks++;
            if (act_rms_q[i] != 1000 || act_pk_q[i] != 1000 || act_edge_q[i] != exp_edge_q[i]) begin
                errors++;
                $display("FAIL alt_window%0d: got rms=%0d pk=%0d edge=%0d want 1000 1000 edge=%0d",
                         i, act_rms_q[i], act_pk_q[i], act_edge_q[i], exp_edge_q[i]);
            end
        end
        checks++;
        if (tmes !== t0 || tmes !== m_tmes) begin
            errors++; $display("FAIL alt_tmes: got %b want %b", tmes, t0);
        end
    endtask

    task automatic test_extremes();
        clear_q();
        for (int i = 0; i < 16; i++) step(1'b1, 12'd0, 1'b0);
        idle(16);
        checks++;
        if (rms !== 12'd2048 || pk !== 12'd2048) begin
            errors++; $display("FAIL extreme_ob: got rms=%0d pk=%0d want 2048 2048", rms, pk);
        end
        checks++;
        if (rms2 !== 12'd2048 || pk2 !== 12'd2048) begin
            errors++; $display("FAIL extreme_tc: got rms=%0d pk=%0d want 2048 2048", rms2, pk2);
        end
    endtask

    task automatic test_abort();
        logic [11:0] r0, p0;
        int n0;
        clear_q();
        for (int i = 0; i < 8; i++) step(1'b1, 12'd2148, 1'b0);
        step(1'b1, 12'd2148, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 12'd2058, 1'b0);
        idle(16);
        checks++;
        if (act_rms_q.size() != 1 || rms !== 12'd10 || pk !== 12'd10) begin
            errors++;
            $display("FAIL abort_window: got %0d ok rms=%0d pk=%0d want 1 ok rms=10 pk=10", act_rms_q.size(), rms, pk);
        end
        for (int i = 0; i < 16; i++) step(1'b1, 12'($urandom), 1'b0);
        idle(4);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL abort_busy_before: got %b want 1", busy);
        end
        r0 = rms; p0 = pk; n0 = act_rms_q.size();
        step(1'b0, 12'd0, 1'b1);
        idle(20);
        checks++;
        if (act_rms_q.size() != n0 || exp_rms_q.size() != n0) begin
            errors++; $display("FAIL abort_no_ok: got %0d ok pulses want %0d", act_rms_q.size(), n0);
        end
        checks++;
        if (rms !== r0 || pk !== p0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold: got rms=%0d pk=%0d busy=%b want %0d %0d 0", rms, pk, busy, r0, p0);
        end
        checks++;
        if (tmes !== m_tmes) begin
            errors++; $display("FAIL abort_tmes: got %b want %b", tmes, m_tmes);
        end
    endtask

    task automatic test_slow_ce();
        int n0;
        clear_q();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i < 8) ? 12'd2051 : 12'd2044, 1'b0);
            idle(4);
        end
        idle(16);
        checks++;
        if (act_rms_q.size() != 1 || rms !== 12'd3 || pk !== 12'd4) begin
            errors++;
            $display("FAIL slow_ce: got %0d ok rms=%0d pk=%0d want 1 ok rms=3 pk=4", act_rms_q.size(), rms, pk);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 12'($urandom), 1'b0);
            if (i < 15) idle(4);
        end
        idle(3);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL rst_busy_before: got %b want 1", busy);
        end
        n0 = act_rms_q.size();
        rst_n = 1'b0;
        step(1'b0, 12'd0, 1'b0);
        rst_n = 1'b1;
        checks++;
        if ({rms, pk, ok, busy, tmes} !== 27'd0) begin
            errors++;
            $display("FAIL rst_busy_outputs: got rms=%0d pk=%0d ok=%b busy=%b tmes=%b want all 0", rms, pk, ok, busy, tmes);
        end
        idle(20);
        checks++;
        if (act_rms_q.size() != n0) begin
            errors++; $display("FAIL rst_busy_no_ok: got %0d ok pulses want %0d", act_rms_q.size(), n0);
        end
    endtask

    task automatic test_random();
        clear_q();
        for (int i = 0; i < 300; i++) step(($urandom % 4) != 0, 12'($urandom), 1'b0);
        idle(16);
        checks++;
        if (act_rms_q.size() != exp_rms_q.size() || act_rms_q.size() == 0) begin
            errors++;
            $display("FAIL random_ok_count: got %0d want %0d", act_rms_q.size(), exp_rms_q.size());
        end
        for (int i = 0; i < act_rms_q.size() && i < exp_rms_q.size(); i++) begin
            checks++;
            if (act_rms_q[i] != exp_rms_q[i] || act_pk_q[i] != exp_pk_q[i] || act_edge_q[i] != exp_edge_q[i]) begin
                errors++;
                $display("FAIL random_window%0d: got rms=%0d pk=%0d edge=%0d want %0d %0d edge=%0d", i,
                         act_rms_q[i], act_pk_q[i], act_edge_q[i], exp_rms_q[i], exp_pk_q[i], exp_edge_q[i]);
            end
        end
        checks++;
        if (int'(rms2) != m_last_rms || int'(pk2) != m_last_pk || tmes !== m_tmes) begin
            errors++;
            $display("FAIL random_final: got rms2=%0d pk2=%0d tmes=%b want %0d %0d %b",
                     rms2, pk2, tmes, m_last_rms, m_last_pk, m_tmes);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_latency();
        test_alternating();
        test_extremes();
        test_abort();
        test_slow_ce();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
